pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised next-generation program-counter unit for the MIPS core. It holds the fetch PC and selects the next PC among these sources, highest priority first:
- exception vector
- exception return
- register jump
- absolute jump
- taken branch
- sequential PC+4

It adds reset, stall, exception handling with EPC capture, and misalignment detection. Conditional branch offsets are sign-extended and shifted left by 2.

Parameters:
ADDR_W, 32, PC width in bits; legal range 8..32.
RESET_VEC, 32'h0000_0000, PC value after reset (low ADDR_W bits used).
EXC_VEC, 32'h0000_0180, exception entry address (low ADDR_W bits used).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  hold PC and all state this cycle.
instruction  input  32  current instruction: [15:0] branch offset, [25:0] jump index.
zero  input  1  ALU zero flag.
branch  input  1  conditional branch decoded.
jump  input  1  absolute jump decoded.
jump_reg  input  1  register jump (jr) decoded.
rs_val  input  ADDR_W  register jump target.
exc  input  1  external exception request.
eret  input  1  return from exception.
pc  output  ADDR_W  current fetch PC.
pc_plus4  output  ADDR_W  pc+4, combinational.
epc  output  ADDR_W  saved exception PC.
exc_taken  output  1  registered one-cycle pulse: exception entered.
bd  output  1  EPC points at a branch whose delay slot faulted.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_VEC, epc=0, exc_taken=0, bd=0, slot state IDLE, pending target=0.
- Arithmetic is modulo 2^ADDR_W. pc+4 wraps from all-ones-minus-3 to 0.
- Branch target:
  - pc_plus4 + (sext(instruction[15:0]) << 2), truncated to ADDR_W.
  - Taken when branch & zero.
- Jump target:
  - Form the 32-bit value {pc_plus4 bits [31:28] zero-extended, instruction[25:0], 2'b00}.
  - Keep its low ADDR_W bits.
- Misalignment:
  - Internal fault condition = jump_reg & (rs_val[1:0] != 0).
  - Handled identically to exc.
- Next-PC priority, one winner per cycle:
  1. exc or misalignment fault: pc <= EXC_VEC, epc <= pc, exc_taken <= 1.
  2. eret: pc <= epc.
  3. jump_reg: pc <= rs_val.
  4. jump: pc <= jump target.
  5. taken branch: pc <= branch target.
  6. otherwise: pc <= pc_plus4.
- exc_taken is high exactly one cycle after the accepting edge.
- Stall:
  - When stall=1, pc, epc, pending and slot state hold. exc_taken <= 0.
  - Exceptions override stall and are accepted even when stall=1.
  - All other requests asserted during stall are dropped. Decode holds them until stall releases.
- Simultaneous events:
  - exc with any redirect: exception wins.
  - jump with branch: jump wins.
  - eret with jump_reg: eret wins.
- Latency: new PC is visible on pc one cycle after the request edge; there is no bubble.
- epc and bd change only on exception entry.

Optional Feature:
Macro: PC_DELAY_SLOT_EN.

Defined (MIPS branch-delay-slot mode):
- A winning jump_reg, jump or taken-branch target is captured into a pending register.
- pc <= pc_plus4 (the delay slot) and the slot state moves IDLE -> SLOT.
- In SLOT, the next non-stalled edge sets pc <= pending and returns to IDLE.
- Redirect requests while in SLOT are ignored.
- Exception in SLOT: epc <= pc-4 (the branch), bd <= 1, state -> IDLE, pending discarded.
- Exception in IDLE: bd <= 0.
- eret always redirects immediately, with no slot.
- Stall holds SLOT.

Undefined:
- Redirects take effect on the next edge.
- Slot state and pending register are absent.
- bd is tied to 0.

Test Plan:
- Reset, then release rst_n with no controls for 3 edges -> pc = 0x0, 0x4, 0x8, 0xC.
- At pc=0x100, instruction[15:0]=0xFFFE, branch=1, zero=1 -> pc=0x0FC. Same with zero=0 -> pc=0x104.
- At pc=0x3000_0010, jump=1, instruction[25:0]=0x000_0040 -> pc=0x3000_0100. Jump and branch together -> jump target wins.
- jump_reg=1, rs_val=0x0000_2002 at pc=0x40 -> pc=0x180, epc=0x40, exc_taken pulses 1 cycle. Then eret=1 -> pc=0x40.
- stall=1 for 4 cycles at pc=0x20 with jump asserted -> pc stays 0x20. exc during stall -> pc=0x180 on that edge. Assert rst_n=0 mid-stall -> pc=RESET_VEC immediately.
- With PC_DELAY_SLOT_EN: taken branch at 0x100 to 0x200 -> pc=0x104 then 0x200. exc in slot -> epc=0x100, bd=1. Wrap test with ADDR_W=8: pc=0xFC -> 0x00.

Source files
------------

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch PC unit that picks the next PC from exceptions, eret and jumps/branches.
//            Optional macro PC_DELAY_SLOT_EN enables MIPS branch-delay-slot mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0180
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [31:0]       instruction,
    input  logic              zero,
    input  logic              branch,
    input  logic              jump,
    input  logic              jump_reg,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic              exc,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] epc,
    output logic              exc_taken,
    output logic              bd
);

    localparam logic [ADDR_W-1:0] C_RESET_PC = RESET_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] C_EXC_PC   = EXC_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] C_FOUR     = ADDR_W'(4);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_epc;
    logic              r_exc_taken;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [31:0]       w_pc_plus4_ext;
    logic [31:0]       w_br_offset;
    logic [31:0]       w_br_sum;
    logic [31:0]       w_j_full;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_j_target;
    logic              w_br_taken;
    logic              w_fault;
    logic              w_exc_accept;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_redirect_target;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_epc_capture;
    logic              w_unused;

    // ------------------------------------------------------------------
    // Target arithmetic (all modulo 2^ADDR_W)
    // ------------------------------------------------------------------
    assign w_pc_plus4     = r_pc + C_FOUR;
    assign w_pc_plus4_ext = 32'(w_pc_plus4);

    assign w_br_offset = {{14{instruction[15]}}, instruction[15:0], 2'b00};
    assign w_br_sum    = w_pc_plus4_ext + w_br_offset;
    assign w_br_target = w_br_sum[ADDR_W-1:0];
    assign w_br_taken  = branch & zero;

    assign w_j_full   = {w_pc_plus4_ext[31:28], instruction[25:0], 2'b00};
    assign w_j_target = w_j_full[ADDR_W-1:0];

    // Opcode field and the truncated upper bits carry no meaning here.
    assign w_unused = &{1'b0, instruction[31:26], w_br_sum, w_j_full, 1'b0};

    // A misaligned register jump is treated exactly like an external exception.
    assign w_fault      = jump_reg & (rs_val[1:0] != 2'b00);
    assign w_exc_accept = exc | w_fault;

    always_comb begin
        w_redirect        = 1'b1;
        w_redirect_target = w_pc_plus4;
        if (jump_reg) begin
            w_redirect_target = rs_val;
        end else if (jump) begin
            w_redirect_target = w_j_target;
        end else if (w_br_taken) begin
            w_redirect_target = w_br_target;
        end else begin
            w_redirect = 1'b0;
        end
    end

`ifdef PC_DELAY_SLOT_EN
    // ------------------------------------------------------------------
    // Delay-slot mode: redirect target parks in r_pending for one fetch
    // ------------------------------------------------------------------
    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_SLOT = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_pending;
    logic              r_bd;

    always_comb begin
        w_pc_nxt = w_pc_plus4;
        if (eret) begin
            w_pc_nxt = r_epc;
        end else if (r_state == C_ST_SLOT) begin
            w_pc_nxt = r_pending;
        end
    end

    // A fault in the slot is reported against the branch that owns it.
    assign w_epc_capture = (r_state == C_ST_SLOT) ? (r_pc - C_FOUR) : r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= C_ST_IDLE;
            r_pending <= '0;
            r_bd      <= 1'b0;
        end else if (w_exc_accept) begin
            r_state   <= C_ST_IDLE;
            r_pending <= '0;
            r_bd      <= (r_state == C_ST_SLOT);
        end else if (!stall) begin
            if (eret) begin
                r_state <= C_ST_IDLE;
            end else if (r_state == C_ST_SLOT) begin
                r_state <= C_ST_IDLE;
            end else if (w_redirect) begin
                r_state   <= C_ST_SLOT;
                r_pending <= w_redirect_target;
            end
        end
    end

    assign bd = r_bd;
`else
    always_comb begin
        w_pc_nxt = w_pc_plus4;
        if (eret) begin
            w_pc_nxt = r_epc;
        end else if (w_redirect) begin
            w_pc_nxt = w_redirect_target;
        end
    end

    assign w_epc_capture = r_pc;
    assign bd            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // PC / EPC registers; exceptions are accepted even while stalled
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= C_RESET_PC;
            r_epc       <= '0;
            r_exc_taken <= 1'b0;
        end else begin
            r_exc_taken <= w_exc_accept;
            if (w_exc_accept) begin
                r_pc  <= C_EXC_PC;
                r_epc <= w_epc_capture;
            end else if (!stall) begin
                r_pc <= w_pc_nxt;
            end
        end
    end

    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign epc       = r_epc;
    assign exc_taken = r_exc_taken;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed self-checking bench for pc_sequencer (32-bit and 8-bit builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pc_sequencer;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b1;
    logic        stall       = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic        zero        = 1'b0;
    logic        branch      = 1'b0;
    logic        jump        = 1'b0;
    logic        jump_reg    = 1'b0;
    logic [31:0] rs_val      = 32'h0;
    logic        exc         = 1'b0;
    logic        eret        = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        exc_taken;
    logic        bd;

    logic        rst8_n = 1'b1;
    logic [7:0]  pc8;
    logic [7:0]  pc8_plus4;
    logic [7:0]  epc8;
    logic        exc_taken8;
    logic        bd8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .instruction(instruction),
        .zero       (zero),
        .branch     (branch),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .rs_val     (rs_val),
        .exc        (exc),
        .eret       (eret),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .epc        (epc),
        .exc_taken  (exc_taken),
        .bd         (bd)
    );

    pc_sequencer #(.ADDR_W(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst8_n),
        .stall      (1'b0),
        .instruction(32'h0),
        .zero       (1'b0),
        .branch     (1'b0),
        .jump       (1'b0),
        .jump_reg   (1'b0),
        .rs_val     (8'h00),
        .exc        (1'b0),
        .eret       (1'b0),
        .pc         (pc8),
        .pc_plus4   (pc8_plus4),
        .epc        (epc8),
        .exc_taken  (exc_taken8),
        .bd         (bd8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall       = 1'b0;
        instruction = 32'h0;
        zero        = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        jump_reg    = 1'b0;
        rs_val      = 32'h0;
        exc         = 1'b0;
        eret        = 1'b0;
    endtask

    // Fires the already-driven redirect; in slot mode the delay slot is fetched first.
    task automatic take_redirect(input string tag, input logic [31:0] slot_pc,
                                 input logic [31:0] tgt);
        step();
        clear_ctrl();
`ifdef PC_DELAY_SLOT_EN
        chk({tag, "_slot"}, pc, slot_pc);
        step();
`else
        if (slot_pc == 32'h0) $display("note: unused slot pc");
`endif
        chk(tag, pc, tgt);
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        jump_reg = 1'b1;
        rs_val   = addr;
        take_redirect("goto", pc + 32'h4, addr);
    endtask

    initial begin
        clear_ctrl();
        #2;
        rst_n  = 1'b0;
        rst8_n = 1'b0;
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_epc", epc, 32'h0);
        chk("rst_exc_taken", {31'h0, exc_taken}, 32'h0);
        chk("rst_bd", {31'h0, bd}, 32'h0);
        chk("rst_pc8", {24'h0, pc8}, 32'h0);

        rst_n = 1'b1;
        step(); chk("seq_4", pc, 32'h4);
        step(); chk("seq_8", pc, 32'h8);
        step(); chk("seq_c", pc, 32'hC);

        // Backward taken branch: 0x104 + (-2 << 2) = 0xFC
        goto_pc(32'h100);
        instruction = 32'h0000_FFFE; branch = 1'b1; zero = 1'b1;
        take_redirect("br_back", 32'h104, 32'h0FC);

        goto_pc(32'h100);
        instruction = 32'h0000_FFFE; branch = 1'b1; zero = 1'b0;
        step(); clear_ctrl();
        chk("br_not_taken", pc, 32'h104);

        // Forward branch 0x104 + (0x3F << 2) = 0x200
        goto_pc(32'h100);
        instruction = 32'h0000_003F; branch = 1'b1; zero = 1'b1;
        take_redirect("br_fwd", 32'h104, 32'h200);

        goto_pc(32'h3000_0010);
        instruction = 32'h0000_0040; jump = 1'b1;
        take_redirect("jump", 32'h3000_0014, 32'h3000_0100);

        goto_pc(32'h3000_0010);
        instruction = 32'h0000_0040; jump = 1'b1; branch = 1'b1; zero = 1'b1;
        take_redirect("jump_over_br", 32'h3000_0014, 32'h3000_0100);

        // Misaligned register jump enters the exception vector
        goto_pc(32'h40);
        jump_reg = 1'b1; rs_val = 32'h0000_2002;
        step(); clear_ctrl();
        chk("mis_pc", pc, 32'h180);
        chk("mis_epc", epc, 32'h40);
        chk("mis_exc_taken", {31'h0, exc_taken}, 32'h1);
        chk("mis_bd", {31'h0, bd}, 32'h0);
        eret = 1'b1;
        step(); clear_ctrl();
        chk("eret_pc", pc, 32'h40);
        chk("eret_exc_taken_low", {31'h0, exc_taken}, 32'h0);
        chk("eret_epc_hold", epc, 32'h40);

        goto_pc(32'h20);
        stall = 1'b1; jump = 1'b1; instruction = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_hold", pc, 32'h20);
        end
        exc = 1'b1;
        step();
        exc = 1'b0;
        chk("stall_exc_pc", pc, 32'h180);
        chk("stall_exc_epc", epc, 32'h20);
        chk("stall_exc_taken", {31'h0, exc_taken}, 32'h1);
        step();
        chk("stall_after_exc_pc", pc, 32'h180);
        chk("stall_exc_taken_pulse", {31'h0, exc_taken}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_epc", epc, 32'h0);
        step();
        clear_ctrl();
        rst_n = 1'b1;
        step();
        chk("post_rst_seq", pc, 32'h4);

`ifdef PC_DELAY_SLOT_EN
        // Exception raised while fetching the delay slot
        goto_pc(32'h100);
        instruction = 32'h0000_003F; branch = 1'b1; zero = 1'b1;
        step(); clear_ctrl();
        chk("slot_pc", pc, 32'h104);
        exc = 1'b1;
        step(); clear_ctrl();
        chk("slot_exc_pc", pc, 32'h180);
        chk("slot_exc_epc", epc, 32'h100);
        chk("slot_exc_bd", {31'h0, bd}, 32'h1);
        eret = 1'b1;
        step(); clear_ctrl();
        chk("slot_eret_pc", pc, 32'h100);
        chk("slot_eret_bd_hold", {31'h0, bd}, 32'h1);
`endif

        // 8-bit instance wraps from 0xFC to 0x00
        rst8_n = 1'b1;
        for (int i = 0; i < 63; i++) step();
        chk("wrap8_pc", {24'h0, pc8}, 32'hFC);
        chk("wrap8_plus4", {24'h0, pc8_plus4}, 32'h00);
        step();
        chk("wrap8_pc_next", {24'h0, pc8}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
